// File: rtl/ram_read_responder_pkg.sv
// ram_read_responder_pkg: shared defaults and FSM state encoding for the window read responder
package ram_read_responder_pkg;
   localparam int DEF_NUM_PORTS = 9;
   localparam int DEF_ADDR_W    = 12;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_READ_LAT  = 1;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stateT;
endpackage

// File: rtl/ram_read_responder_read_tag_pipe.sv
// read_tag_pipe: READ_LAT-deep shift register carrying {valid, lane index} beside each RAM read
module read_tag_pipe #(
   parameter int DEPTH = 1,
   parameter int TAG_W = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   output logic [TAG_W-1:0] o_tag
);
   logic [DEPTH-1:0] vld;
   logic [TAG_W-1:0] tag [DEPTH];
   always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) begin
         vld <= '0;
         for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
      end else begin
         vld[0] <= i_valid;
         tag[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            tag[i] <= tag[i-1];
         end
      end
   assign o_valid = vld[DEPTH-1];
   assign o_tag   = tag[DEPTH-1];
endmodule

// File: rtl/ram_read_responder.sv
// ram_read_responder: serialises a window of packed read addresses onto one RAM and returns all words at once
module ram_read_responder
   import ram_read_responder_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int READ_LAT  = DEF_READ_LAT
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_start,
   input  logic                        i_mask,
   input  logic [NUM_PORTS*ADDR_W-1:0] i_addrRead,
   output logic [ADDR_W-1:0]           o_memAddr,
   output logic                        o_memRe,
   input  logic [DATA_W-1:0]           i_memData,
   output logic [NUM_PORTS*DATA_W-1:0] o_data,
   output logic                        o_validRam,
   output logic                        o_busy
);
   localparam int CNT_W = $clog2(NUM_PORTS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PORTS - 1);
   stateT state, stateNext;
   logic [CNT_W-1:0] counter, tagIdx;
   logic tagValid;
   logic [NUM_PORTS*ADDR_W-1:0] addrLatch;
   read_tag_pipe #(.DEPTH(READ_LAT), .TAG_W(CNT_W)) u_tagPipe (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_valid (o_memRe),
      .i_tag   (counter),
      .o_valid (tagValid),
      .o_tag   (tagIdx)
   );
   always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) begin
         state     <= IDLE;
         counter   <= '0;
         addrLatch <= '0;
         o_data    <= '0;
      end else begin
         state <= stateNext;
         if (state == IDLE && i_start) begin
            counter <= '0;
            if (i_mask) addrLatch <= i_addrRead;
            else o_data <= '0;
         end
         if (state == ISSUE) counter <= (counter == LAST) ? '0 : counter + 1'b1;
         // returning words land in their own lane; the rest hold their last value
         if (tagValid) o_data[tagIdx*DATA_W +: DATA_W] <= i_memData;
      end
   always_comb begin
      stateNext  = state;
      o_memRe    = 1'b0;
      o_memAddr  = '0;
      o_validRam = 1'b0;
      case (state)
         IDLE:  if (i_start) stateNext = i_mask ? ISSUE : DONE;
         ISSUE: begin
            o_memRe   = 1'b1;
            o_memAddr = addrLatch[counter*ADDR_W +: ADDR_W];
            if (counter == LAST) stateNext = DRAIN;
         end
         DRAIN: if (tagValid && tagIdx == LAST) stateNext = DONE;
         DONE: begin
            o_validRam = 1'b1;
            stateNext  = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end
   assign o_busy = state != IDLE;
endmodule

// File: tb/tb_ram_read_responder.sv
// tb_ram_read_responder: directed checks of timing, masking, busy-ignore, reset abort and READ_LAT=3
module tb_ram_read_responder;
   logic clk, rstN, start1, start3, mask;
   logic [107:0] addrRead;
   logic [11:0] memAddr1, memAddr3;
   logic memRe1, memRe3, valid1, valid3, busy1, busy3;
   logic [15:0] memData1, memData3, q3a, q3b;
   logic [143:0] data1, data3;
   logic [15:0] mem [4096];
   int nChecks = 0, nErrors = 0;
   ram_read_responder dut1 (
      .i_clk(clk), .i_reset(rstN), .i_start(start1), .i_mask(mask), .i_addrRead(addrRead),
      .o_memAddr(memAddr1), .o_memRe(memRe1), .i_memData(memData1),
      .o_data(data1), .o_validRam(valid1), .o_busy(busy1));
   ram_read_responder #(.READ_LAT(3)) dut3 (
      .i_clk(clk), .i_reset(rstN), .i_start(start3), .i_mask(mask), .i_addrRead(addrRead),
      .o_memAddr(memAddr3), .o_memRe(memRe3), .i_memData(memData3),
      .o_data(data3), .o_validRam(valid3), .o_busy(busy3));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) if (memRe1) memData1 <= mem[memAddr1];
   always @(posedge clk) begin
      if (memRe3) q3a <= mem[memAddr3];
      q3b <= q3a;
      memData3 <= q3b;
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic setSeq(input int base);
      for (int k = 0; k < 9; k++) addrRead[k*12 +: 12] = 12'(base + k);
   endtask
   initial begin
      int a5 [9] = '{7, 7, 0, 4095, 12, 3, 3, 9, 1};
      int reCnt;
      for (int a = 0; a < 4096; a++) mem[a] = 16'(a + 100);
      rstN = 0; start1 = 0; start3 = 0; mask = 0; addrRead = '0;
      step(); step();
      chk("rst data", data1, 0);
      chk("rst valid", valid1, 0);
      chk("rst busy", busy1, 0);
      chk("rst re", memRe1, 0);
      chk("rst addr", memAddr1, 0);
      rstN = 1;
      step();
      chk("idle busy", busy1, 0);
      // test 1: contiguous window, READ_LAT=1
      start1 = 1; mask = 1; setSeq(0); reCnt = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 1) start1 = 0;
         reCnt += int'(memRe1);
         chk("t1 valid", valid1, c == 11);
         chk("t1 busy", busy1, c <= 11);
         chk("t1 re", memRe1, c <= 9);
         if (c <= 9) chk("t1 addr", memAddr1, c - 1);
         if (c == 11) for (int k = 0; k < 9; k++) chk("t1 lane", data1[k*16 +: 16], 100 + k);
      end
      chk("t1 re count", reCnt, 9);
      // test 2: masked request clears o_data without touching the RAM
      start1 = 1; mask = 0;
      step();
      start1 = 0;
      chk("t2 valid", valid1, 1);
      chk("t2 data", data1, 0);
      chk("t2 re", memRe1, 0);
      step();
      chk("t2 valid end", valid1, 0);
      chk("t2 data hold", data1, 0);
      // test 3: top-of-memory addresses, late address change and ignored re-start
      start1 = 1; mask = 1; setSeq(4087);
      for (int c = 1; c <= 14; c++) begin
         step();
         if (c == 1) begin start1 = 0; setSeq(500); end
         if (c == 4) start1 = 1;
         if (c == 5) start1 = 0;
         chk("t3 valid", valid1, c == 11);
         chk("t3 busy", busy1, c <= 11);
         if (c == 11) for (int k = 0; k < 9; k++) chk("t3 lane", data1[k*16 +: 16], 4187 + k);
      end
      // test 4: reset mid-operation aborts the request
      start1 = 1; setSeq(10);
      for (int c = 1; c <= 5; c++) begin
         step();
         if (c == 1) start1 = 0;
      end
      rstN = 0;
      #1;
      chk("t4 rst data", data1, 0);
      chk("t4 rst valid", valid1, 0);
      chk("t4 rst busy", busy1, 0);
      chk("t4 rst re", memRe1, 0);
      chk("t4 rst addr", memAddr1, 0);
      step();
      chk("t4 rst hold busy", busy1, 0);
      rstN = 1;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("t4 no valid", valid1, 0);
      end
      start1 = 1; setSeq(20);
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 1) start1 = 0;
         chk("t4b valid", valid1, c == 11);
         if (c == 11) for (int k = 0; k < 9; k++) chk("t4b lane", data1[k*16 +: 16], 120 + k);
      end
      step();
      // test 5: READ_LAT=3, repeated and non-contiguous lanes
      start3 = 1;
      for (int k = 0; k < 9; k++) addrRead[k*12 +: 12] = 12'(a5[k]);
      for (int c = 1; c <= 14; c++) begin
         step();
         if (c == 1) start3 = 0;
         chk("t5 valid", valid3, c == 13);
         chk("t5 busy", busy3, c <= 13);
         if (c == 13) for (int k = 0; k < 9; k++) chk("t5 lane", data3[k*16 +: 16], 16'(a5[k] + 100));
      end
      // test 6: back-to-back requests, lanes overwrite one by one
      start1 = 1; setSeq(30);
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 1) start1 = 0;
      end
      chk("t6a valid", valid1, 1);
      step();
      start1 = 1; setSeq(50);
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 1) start1 = 0;
         chk("t6 valid", valid1, c == 11);
         for (int k = 0; k < 9; k++) chk("t6 lane", data1[k*16 +: 16], (c >= k + 3) ? 150 + k : 130 + k);
      end
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule
